ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameters: DAT_WID, default 24, sample width; RAM_WORD, default 16, RAM word width; RAM_WID, default 32, address/command data width.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd  input  `RAM_READER_CMD_WID; cmd_data  input  RAM_WID; cmd_active  input  1; cmd_finished  output  1; cmd_data_out  output  RAM_WID  (control port).
REQ-005 SHALL have ports addr  output  RAM_WID; read  output  1; word  input  RAM_WORD; valid  input  1  (RAM read port).
REQ-006 SHALL have ports data  output  DAT_WID; data_valid  output  1; data_ready  input  1  (sample stream).

Function
REQ-007 SHALL hold registers base, end_addr, count (RAM_WID each), plus cur_addr and remaining.
REQ-008 Control handshake SHALL be 4-phase: on cmd_active rising, execute once, raise cmd_finished; drop cmd_finished the cycle after cmd_active is seen low.
REQ-009 Commands: SET_BASE, SET_END, SET_COUNT load cmd_data; START loads cur_addr=base, remaining=count, enters REQ_LO; ABORT returns to IDLE; GET_ADDR returns cur_addr; GET_REMAINING returns remaining.
REQ-010 SET_*/START while not IDLE SHALL be ignored, cmd_data_out=32'hFFFFFFFF; otherwise cmd_data_out=0 for writes.
REQ-011 START with count=0 SHALL stay IDLE, no RAM access.
REQ-012 FSM states: IDLE, REQ_LO, REL_LO, REQ_HI, REL_HI, PRESENT.
REQ-013 REQ_x: read=1, addr=cur_addr stable until valid=1; on valid, latch word into the lo or hi half, drop read, go REL_x.
REQ-014 REL_x: wait valid=0; then cur_addr advances by RAM_WORD/8 (2); REL_LO goes to REQ_HI, REL_HI goes to PRESENT.
REQ-015 Address wrap: when advanced address equals end_addr, cur_addr SHALL become base in the same cycle.
REQ-016 Sample assembly: data = {hi[DAT_WID-RAM_WORD-1:0], lo}; the remaining upper bits of hi are discarded.
REQ-017 PRESENT: data_valid=1, data held stable until data_ready=1; on the transfer cycle, remaining decrements; if it reaches 0 go IDLE, else REQ_LO.
REQ-018 data_valid SHALL be 0 outside PRESENT; data_ready outside PRESENT SHALL be ignored.
REQ-019 ABORT mid-transaction SHALL drop read and data_valid next cycle; a pending valid from RAM SHALL be ignored.
REQ-020 Latency: REQ_LO entry to data_valid is 4 cycles plus the RAM valid assert/deassert delays.

Reset
REQ-021 On rst_n low, asynchronously: state=IDLE; read, data_valid, cmd_finished = 0; addr, data, cmd_data_out, base, end_addr, count, cur_addr, remaining = 0.
REQ-022 Reset mid-transaction SHALL abandon it; no sample is emitted after release until a new START.

Structure
REQ-023 Command codes and `RAM_READER_CMD_WID (3) SHALL live in shared header ram_reader_cmds.vh: SET_BASE=0, SET_END=1, SET_COUNT=2, START=3, ABORT=4, GET_ADDR=5, GET_REMAINING=6.
REQ-024 Single module; no sub-module is required.

Verification
REQ-025 base=0x100, end=0x200, count=2, RAM returns 0x5678, 0x0012, 0x9ABC, 0x00FF -> data 0x125678, then 0xFF9ABC; reads at 0x100, 0x102, 0x104, 0x106; IDLE after.
REQ-026 base=0x100, end=0x104, count=2 -> addresses 0x100, 0x102, 0x100, 0x102 (wrap).
REQ-027 data_ready low for 20 cycles in PRESENT -> data and data_valid stable, no RAM read issued, remaining unchanged.
REQ-028 SET_BASE during a transfer -> cmd_data_out=0xFFFFFFFF, base unchanged; GET_REMAINING mid-run returns the correct count.
REQ-029 ABORT while read=1 -> read=0 next cycle, then valid pulses are ignored; rst_n low in REQ_HI -> all outputs 0 immediately.
REQ-030 START with count=0 -> cmd_finished handshake completes, read never asserts.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM sample reader: command codes, command width
// and FSM state encodings.
`ifndef RAM_READER_CMD_WID
`define RAM_READER_CMD_WID 3
`endif

package ram_reader_pkg;

  localparam int CMD_WID = `RAM_READER_CMD_WID;

  localparam logic [CMD_WID-1:0] CMD_SET_BASE      = CMD_WID'(0);
  localparam logic [CMD_WID-1:0] CMD_SET_END       = CMD_WID'(1);
  localparam logic [CMD_WID-1:0] CMD_SET_COUNT     = CMD_WID'(2);
  localparam logic [CMD_WID-1:0] CMD_START         = CMD_WID'(3);
  localparam logic [CMD_WID-1:0] CMD_ABORT         = CMD_WID'(4);
  localparam logic [CMD_WID-1:0] CMD_GET_ADDR      = CMD_WID'(5);
  localparam logic [CMD_WID-1:0] CMD_GET_REMAINING = CMD_WID'(6);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ_LO  = 3'd1;
  localparam logic [2:0] ST_REL_LO  = 3'd2;
  localparam logic [2:0] ST_REQ_HI  = 3'd3;
  localparam logic [2:0] ST_REL_HI  = 3'd4;
  localparam logic [2:0] ST_PRESENT = 3'd5;

  // Configuration writes and START are refused unless the reader is idle.
  function automatic logic cmd_needs_idle(input logic [CMD_WID-1:0] c);
    return (c == CMD_SET_BASE) || (c == CMD_SET_END) ||
           (c == CMD_SET_COUNT) || (c == CMD_START);
  endfunction

endpackage

// File: rtl/ram_reader.sv
// Reads pairs of RAM words from a circular address window and presents each
// pair as one sample on a valid/ready stream; configured via a 4-phase command port.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int DAT_WID  = 24,
  parameter int RAM_WORD = 16,
  parameter int RAM_WID  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [`RAM_READER_CMD_WID-1:0] cmd,
  input  logic [RAM_WID-1:0]             cmd_data,
  input  logic                           cmd_active,
  output logic                           cmd_finished,
  output logic [RAM_WID-1:0]             cmd_data_out,
  output logic [RAM_WID-1:0]             addr,
  output logic                           read,
  input  logic [RAM_WORD-1:0]            word,
  input  logic                           valid,
  output logic [DAT_WID-1:0]             data,
  output logic                           data_valid,
  input  logic                           data_ready
);

  localparam int HI_KEEP = DAT_WID - RAM_WORD;
  localparam logic [RAM_WID-1:0] STEP = RAM_WID'(RAM_WORD / 8);

  logic [2:0]          state_reg;
  logic [RAM_WID-1:0]  base_reg;
  logic [RAM_WID-1:0]  end_reg;
  logic [RAM_WID-1:0]  count_reg;
  logic [RAM_WID-1:0]  cur_addr_reg;
  logic [RAM_WID-1:0]  remaining_reg;
  logic [RAM_WORD-1:0] lo_reg;
  logic [HI_KEEP-1:0]  hi_reg;
  logic                cmd_active_q;

  logic [RAM_WID-1:0] adv_addr;
  logic [RAM_WID-1:0] addr_next;
  logic               cmd_start;
  logic               is_idle;

  // Advancing onto end_addr wraps straight back to base in the same cycle.
  assign adv_addr  = cur_addr_reg + STEP;
  assign addr_next = (adv_addr == end_reg) ? base_reg : adv_addr;
  assign cmd_start = cmd_active && !cmd_active_q;
  assign is_idle   = (state_reg == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      end_reg       <= '0;
      count_reg     <= '0;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      lo_reg        <= '0;
      hi_reg        <= '0;
      cmd_active_q  <= 1'b0;
      cmd_finished  <= 1'b0;
      cmd_data_out  <= '0;
      addr          <= '0;
      read          <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
    end else begin
      cmd_active_q <= cmd_active;

      case (state_reg)
        ST_REQ_LO: if (valid) begin
          lo_reg    <= word;
          read      <= 1'b0;
          state_reg <= ST_REL_LO;
        end
        ST_REL_LO: if (!valid) begin
          cur_addr_reg <= addr_next;
          addr         <= addr_next;
          read         <= 1'b1;
          state_reg    <= ST_REQ_HI;
        end
        ST_REQ_HI: if (valid) begin
          hi_reg    <= word[HI_KEEP-1:0];
          read      <= 1'b0;
          state_reg <= ST_REL_HI;
        end
        ST_REL_HI: if (!valid) begin
          cur_addr_reg <= addr_next;
          data         <= {hi_reg, lo_reg};
          data_valid   <= 1'b1;
          state_reg    <= ST_PRESENT;
        end
        ST_PRESENT: if (data_ready) begin
          data_valid    <= 1'b0;
          remaining_reg <= remaining_reg - RAM_WID'(1);
          if (remaining_reg == RAM_WID'(1)) begin
            state_reg <= ST_IDLE;
          end else begin
            addr      <= cur_addr_reg;
            read      <= 1'b1;
            state_reg <= ST_REQ_LO;
          end
        end
        default: ;
      endcase

      // Commands sit after the FSM so ABORT overrides any step taken this cycle.
      if (cmd_start) begin
        cmd_finished <= 1'b1;
        if (cmd_needs_idle(cmd) && !is_idle) begin
          cmd_data_out <= '1;
        end else begin
          case (cmd)
            CMD_SET_BASE:  begin base_reg  <= cmd_data; cmd_data_out <= '0; end
            CMD_SET_END:   begin end_reg   <= cmd_data; cmd_data_out <= '0; end
            CMD_SET_COUNT: begin count_reg <= cmd_data; cmd_data_out <= '0; end
            CMD_START: begin
              cmd_data_out <= '0;
              if (count_reg != '0) begin
                cur_addr_reg  <= base_reg;
                remaining_reg <= count_reg;
                addr          <= base_reg;
                read          <= 1'b1;
                state_reg     <= ST_REQ_LO;
              end
            end
            CMD_ABORT: begin
              state_reg    <= ST_IDLE;
              read         <= 1'b0;
              data_valid   <= 1'b0;
              cmd_data_out <= '0;
            end
            CMD_GET_ADDR:      cmd_data_out <= cur_addr_reg;
            CMD_GET_REMAINING: cmd_data_out <= remaining_reg;
            default:           cmd_data_out <= '0;
          endcase
        end
      end else if (!cmd_active) begin
        cmd_finished <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_reader.sv
// Randomized bench for ram_reader: a RAM responder with random latencies, a
// queue-based expectation model of addresses and samples, and command checks.
module tb_ram_reader;
  import ram_reader_pkg::*;

  localparam int DAT_WID  = 24;
  localparam int RAM_WORD = 16;
  localparam int RAM_WID  = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2:0]          cmd = '0;
  logic [RAM_WID-1:0]  cmd_data = '0;
  logic                cmd_active = 1'b0;
  logic                cmd_finished;
  logic [RAM_WID-1:0]  cmd_data_out;
  logic [RAM_WID-1:0]  addr;
  logic                read;
  logic [RAM_WORD-1:0] word = '0;
  logic                valid = 1'b0;
  logic [DAT_WID-1:0]  data;
  logic                data_valid;
  logic                data_ready = 1'b0;

  ram_reader #(.DAT_WID(DAT_WID), .RAM_WORD(RAM_WORD), .RAM_WID(RAM_WID)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_data(cmd_data), .cmd_active(cmd_active),
    .cmd_finished(cmd_finished), .cmd_data_out(cmd_data_out), .addr(addr), .read(read),
    .word(word), .valid(valid), .data(data), .data_valid(data_valid), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:511];
  logic [31:0] exp_addr[$];
  logic [23:0] exp_data[$];
  int          model_remaining = 0;
  logic [31:0] m_base = '0, m_end = '0, m_count = '0;
  bit          stall = 1'b0;
  int          extra_delay = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a);
    return (a + 32'd2 == m_end) ? m_base : a + 32'd2;
  endfunction

  // Expected read addresses and samples for one START, from the window rules.
  task automatic expect_run();
    logic [31:0] a, a0, a1;
    a = m_base;
    for (int i = 0; i < int'(m_count); i++) begin
      a0 = a; a = nxt(a);
      a1 = a; a = nxt(a);
      exp_addr.push_back(a0);
      exp_addr.push_back(a1);
      exp_data.push_back({mem[a1[9:1]][7:0], mem[a0[9:1]]});
    end
    model_remaining = int'(m_count);
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [31:0] d,
                        output logic [31:0] r, output logic rd_snap);
    int n;
    @(negedge clk);
    cmd = c; cmd_data = d; cmd_active = 1'b1;
    n = 0;
    while (!cmd_finished && n < 20) begin @(negedge clk); n++; end
    check("cmd_fin", {31'd0, cmd_finished}, 32'd1);
    r = cmd_data_out;
    rd_snap = read;
    cmd_active = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (cmd_finished && n < 20);
    check("cmd_drop", {31'd0, cmd_finished}, 32'd0);
    $display("cmd %0d data %h -> %h", c, d, r);
  endtask

  task automatic cfg(input logic [31:0] b, input logic [31:0] e, input logic [31:0] cnt);
    logic [31:0] r; logic s;
    do_cmd(CMD_SET_BASE, b, r, s);    check("set_base_ret", r, 32'd0);
    do_cmd(CMD_SET_END, e, r, s);     check("set_end_ret", r, 32'd0);
    do_cmd(CMD_SET_COUNT, cnt, r, s); check("set_count_ret", r, 32'd0);
    m_base = b; m_end = e; m_count = cnt;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_data.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("run_done", exp_data.size(), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  // RAM responder: random latency to assert valid and to drop it after read falls.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (read) begin
        d = $urandom_range(0, 3) + extra_delay;
        repeat (d) @(negedge clk);
        word = mem[addr[9:1]];
        valid = 1'b1;
        d = 0;
        while (read && d < 200) begin @(negedge clk); d++; end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        valid = 1'b0;
      end
    end
  end

  // Read-request monitor: each rising read must carry the next expected address.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (read && !prev) begin
        if (exp_addr.size() == 0) check("unexp_read", {31'd0, read}, 32'd0);
        else check("rd_addr", addr, exp_addr.pop_front());
      end
      prev = read;
    end
  end

  // Sample sink: picks data_ready for the coming edge, then scores any transfer.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      data_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (data_valid && data_ready && rst_n) begin
        if (exp_data.size() == 0) begin
          check("unexp_sample", {31'd0, data_valid}, 32'd0);
        end else begin
          e = exp_data.pop_front();
          check("sample", {8'd0, data}, {8'd0, e});
          model_remaining--;
          $display("sample %h expected %h", data, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, b, e, cnt;
    logic s, ok_dv, ok_rd, ok_dat;
    logic [23:0] held;
    int n;

    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_cmd_finished", {31'd0, cmd_finished}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_data", {8'd0, data}, 32'd0);
    check("rst_cmd_data_out", cmd_data_out, 32'd0);
    rst_n = 1'b1;

    // Directed window with known RAM contents.
    mem[9'h080] = 16'h5678; mem[9'h081] = 16'h0012;
    mem[9'h082] = 16'h9ABC; mem[9'h083] = 16'h00FF;
    cfg(32'h100, 32'h200, 32'd2);
    exp_addr = '{32'h100, 32'h102, 32'h104, 32'h106};
    exp_data = '{24'h125678, 24'hFF9ABC};
    model_remaining = 2;
    do_cmd(CMD_START, 32'd0, r, s); check("start_ret", r, 32'd0);
    wait_done();
    do_cmd(CMD_GET_REMAINING, 32'd0, r, s); check("idle_remaining", r, 32'd0);

    // Wrapping window.
    cfg(32'h100, 32'h104, 32'd2);
    expect_run();
    do_cmd(CMD_START, 32'd0, r, s);
    wait_done();
    do_cmd(CMD_GET_ADDR, 32'd0, r, s); check("wrap_addr", r, 32'h100);

    for (int run = 0; run < 5; run++) begin
      b   = 32'h100 + 32'(2 * $urandom_range(0, 63));
      e   = b + 32'(2 * $urandom_range(1, 8));
      cnt = 32'($urandom_range(1, 4));
      cfg(b, e, cnt);
      expect_run();
      if (run == 2) begin
        // Hold data_ready low on the first sample and probe the command port.
        stall = 1'b1;
        do_cmd(CMD_START, 32'd0, r, s);
        n = 0;
        while (!data_valid && n < 200) begin @(negedge clk); n++; end
        check("stall_reach", {31'd0, data_valid}, 32'd1);
        held = data;
        ok_dv = 1'b1; ok_rd = 1'b1; ok_dat = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (!data_valid) ok_dv = 1'b0;
          if (read) ok_rd = 1'b0;
          if (data !== held) ok_dat = 1'b0;
        end
        check("stall_valid", {31'd0, ok_dv}, 32'd1);
        check("stall_noread", {31'd0, ok_rd}, 32'd1);
        check("stall_data", {31'd0, ok_dat}, 32'd1);
        do_cmd(CMD_GET_REMAINING, 32'd0, r, s);
        check("mid_remaining", r, 32'(model_remaining));
        do_cmd(CMD_SET_BASE, 32'h3F0, r, s);
        check("busy_set_base", r, 32'hFFFFFFFF);
        do_cmd(CMD_START, 32'd0, r, s);
        check("busy_start", r, 32'hFFFFFFFF);
        stall = 1'b0;
        wait_done();
        // Same configuration again: the refused SET_BASE must not have landed.
        expect_run();
        do_cmd(CMD_START, 32'd0, r, s);
        wait_done();
      end else begin
        do_cmd(CMD_START, 32'd0, r, s);
        wait_done();
      end
    end

    // ABORT while a read is outstanding; the late RAM valid must be ignored.
    extra_delay = 8;
    cfg(32'h140, 32'h200, 32'd3);
    expect_run();
    do_cmd(CMD_START, 32'd0, r, s);
    n = 0;
    while (!read && n < 50) @(negedge clk);
    do_cmd(CMD_ABORT, 32'd0, r, s);
    check("abort_read", {31'd0, s}, 32'd0);
    exp_addr.delete(); exp_data.delete(); model_remaining = 0;
    repeat (30) @(negedge clk);
    check("abort_idle_dv", {31'd0, data_valid}, 32'd0);
    extra_delay = 0;

    // Reset while the high word is being requested.
    cfg(32'h180, 32'h300, 32'd2);
    expect_run();
    do_cmd(CMD_START, 32'd0, r, s);
    n = 0;
    while (!(read && addr == 32'h182) && n < 200) begin @(negedge clk); n++; end
    check("reach_req_hi", addr, 32'h182);
    rst_n = 1'b0;
    #1;
    check("rrst_read", {31'd0, read}, 32'd0);
    check("rrst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rrst_addr", addr, 32'd0);
    check("rrst_data", {8'd0, data}, 32'd0);
    check("rrst_cmd_data_out", cmd_data_out, 32'd0);
    exp_addr.delete(); exp_data.delete(); model_remaining = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    do_cmd(CMD_GET_REMAINING, 32'd0, r, s); check("rrst_remaining", r, 32'd0);
    do_cmd(CMD_GET_ADDR, 32'd0, r, s);      check("rrst_cur_addr", r, 32'd0);

    // START with a zero count completes the handshake and never reads.
    cfg(32'h100, 32'h200, 32'd0);
    do_cmd(CMD_START, 32'd0, r, s); check("zero_start_ret", r, 32'd0);
    repeat (30) @(negedge clk);
    check("zero_no_read", {31'd0, read}, 32'd0);
    do_cmd(CMD_SET_BASE, 32'h120, r, s); check("zero_still_idle", r, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
